// File: rtl/icap_cfg_reg_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : icap_cfg_reg_reader_if
// Description : Request/response channel between the register block
//               (requester) and the ICAPE3 readback sequencer (responder).
//               master modport : requester side (issues req, accepts rsp)
//               slave  modport : sequencer side (accepts req, returns rsp)
// Signals     : req_valid/req_ready/req_addr[4:0]   read request
//               rsp_valid/rsp_ready/rsp_data[31:0]/rsp_err   read result
// Revision    : 1.0  initial release
// ============================================================================
interface icap_cfg_reg_reader_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/icap_cfg_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : icap_cfg_reg_reader
// Description : ICAPE3 readback sequencer. Per request it issues a dummy +
//               sync + Type-1 read header, switches the port to read, captures
//               one 32-bit configuration register, switches back and DESYNCs.
//               All outputs are registered; ICAP data is bit-reversed per byte.
// Ports       : axi_aclk     clock (also ICAPE3.CLK)
//               axi_aresetn  asynchronous active-low reset
//               bus          request/response channel (slave modport)
//               icap_csib    to ICAPE3.CSIB
//               icap_rdwrb   to ICAPE3.RDWRB (0 = write, 1 = read)
//               icap_i       to ICAPE3.I (byte-wise bit-reversed)
//               icap_o       from ICAPE3.O (byte-wise bit-reversed)
//               icap_avail   from ICAPE3.AVAIL
// Options     : ICAP_RD_TIMEOUT_EN  builds a watchdog over WAIT_AVAIL and the
//               header/read phases; on expiry returns rsp_err=1, DEADDEAD.
//               Undefined: no counter, rsp_err tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module icap_cfg_reg_reader #(
   parameter int READ_LAT       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire logic               axi_aclk,
   input  wire logic               axi_aresetn,
   icap_cfg_reg_reader_if.slave    bus,
   output logic                    icap_csib,
   output logic                    icap_rdwrb,
   output logic [31:0]             icap_i,
   input  wire logic [31:0]        icap_o,
   input  wire logic               icap_avail
);

   localparam int CNT_W = (READ_LAT > 6) ? $clog2(READ_LAT + 1) : 3;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_AVAIL = 3'd1;
   localparam logic [2:0] S_WR_HDR     = 3'd2;
   localparam logic [2:0] S_SW_RD      = 3'd3;
   localparam logic [2:0] S_RD         = 3'd4;
   localparam logic [2:0] S_SW_WR      = 3'd5;
   localparam logic [2:0] S_DESYNC     = 3'd6;
   localparam logic [2:0] S_RESP       = 3'd7;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       addr;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic [31:0]      rsp_data_q;

`ifdef ICAP_RD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0]  wd;
   logic             rsp_err_q;
   assign bus.rsp_err = rsp_err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;

   // ICAPE3 expects each byte with its bit order reversed.
   function automatic logic [31:0] bitrev_bytes(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            r[8*b + i] = w[8*b + 7 - i];
         end
      end
      return r;
   endfunction

   // Dummy, sync, NOOP, Type-1 read of 1 word from register a, NOOP, NOOP.
   function automatic logic [31:0] hdr_word(input logic [2:0] idx, input logic [4:0] a);
      logic [31:0] w;
      case (idx)
         3'd0:    w = 32'hFFFF_FFFF;
         3'd1:    w = 32'hAA99_5566;
         3'd3:    w = 32'h2800_0001 | {14'd0, a, 13'd0};
         default: w = 32'h2000_0000;
      endcase
      return w;
   endfunction

   // Type-1 write CMD = DESYNC, then two NOOPs to flush.
   function automatic logic [31:0] desync_word(input logic [1:0] idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = 32'h3000_8001;
         2'd1:    w = 32'h0000_000D;
         default: w = 32'h2000_0000;
      endcase
      return w;
   endfunction

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state       <= S_IDLE;
         cnt         <= '0;
         addr        <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         icap_csib   <= 1'b1;
         icap_rdwrb  <= 1'b0;
         icap_i      <= 32'hFFFF_FFFF;
`ifdef ICAP_RD_TIMEOUT_EN
         wd          <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  addr        <= bus.req_addr;
                  req_ready_q <= 1'b0;
                  state       <= S_WAIT_AVAIL;
`ifdef ICAP_RD_TIMEOUT_EN
                  // The accept edge counts as the first watchdog cycle.
                  wd          <= WD_W'(1);
`endif
               end
            end

            S_WAIT_AVAIL: begin
               if (icap_avail) begin
                  state      <= S_WR_HDR;
                  icap_csib  <= 1'b0;
                  icap_rdwrb <= 1'b0;
                  icap_i     <= bitrev_bytes(hdr_word(3'd0, addr));
                  cnt        <= CNT_W'(1);
`ifdef ICAP_RD_TIMEOUT_EN
                  wd         <= WD_W'(1);
`endif
               end
`ifdef ICAP_RD_TIMEOUT_EN
               else if (wd == WD_W'(TIMEOUT_CYCLES)) begin
                  state       <= S_RESP;
                  icap_csib   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= 32'hDEAD_DEAD;
               end else begin
                  wd <= wd + WD_W'(1);
               end
`endif
            end

            S_WR_HDR: begin
`ifdef ICAP_RD_TIMEOUT_EN
               wd <= wd + WD_W'(1);
`endif
               if (cnt == CNT_W'(6)) begin
                  // Deselect before turning the port around.
                  state      <= S_SW_RD;
                  icap_csib  <= 1'b1;
                  icap_rdwrb <= 1'b1;
                  icap_i     <= 32'hFFFF_FFFF;
               end else begin
                  icap_i <= bitrev_bytes(hdr_word(cnt[2:0], addr));
                  cnt    <= cnt + CNT_W'(1);
               end
            end

            S_SW_RD: begin
`ifdef ICAP_RD_TIMEOUT_EN
               wd <= wd + WD_W'(1);
`endif
               state     <= S_RD;
               icap_csib <= 1'b0;
               cnt       <= CNT_W'(1);
            end

            S_RD: begin
`ifdef ICAP_RD_TIMEOUT_EN
               wd <= wd + WD_W'(1);
               if (wd == WD_W'(TIMEOUT_CYCLES)) begin
                  state       <= S_RESP;
                  icap_csib   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= 32'hDEAD_DEAD;
               end else
`endif
               if (cnt == CNT_W'(READ_LAT)) begin
                  // cnt equals READ_LAT during the final read cycle.
                  rsp_data_q <= bitrev_bytes(icap_o);
                  state      <= S_SW_WR;
                  icap_csib  <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_SW_WR: begin
               if (cnt == '0) begin
                  icap_rdwrb <= 1'b0;
                  cnt        <= CNT_W'(1);
               end else begin
                  state     <= S_DESYNC;
                  icap_csib <= 1'b0;
                  icap_i    <= bitrev_bytes(desync_word(2'd0));
                  cnt       <= CNT_W'(1);
               end
            end

            S_DESYNC: begin
               if (cnt == CNT_W'(4)) begin
                  state       <= S_RESP;
                  icap_csib   <= 1'b1;
                  icap_i      <= 32'hFFFF_FFFF;
                  rsp_valid_q <= 1'b1;
`ifdef ICAP_RD_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
               end else begin
                  icap_i <= bitrev_bytes(desync_word(cnt[1:0]));
                  cnt    <= cnt + CNT_W'(1);
               end
            end

            S_RESP: begin
               if (bus.rsp_ready) begin
                  state       <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  // csib is already high here, so the turnaround is safe.
                  icap_rdwrb  <= 1'b0;
               end
            end

            default: begin
               state       <= S_IDLE;
               icap_csib   <= 1'b1;
               icap_rdwrb  <= 1'b0;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icap_cfg_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_icap_cfg_reg_reader
// Description : Directed self-checking bench for icap_cfg_reg_reader with a
//               small ICAPE3 read model (returns data on the final read cycle).
// Revision    : 1.0  initial release
// ============================================================================
module tb_icap_cfg_reg_reader;
   localparam int READ_LAT       = 4;
   localparam int TIMEOUT_CYCLES = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csib, rdwrb, avail;
   logic [31:0] icap_i, icap_o, rd_val;
   int          rdcnt;
   int          checks = 0;
   int          errors = 0;
   int          proto_viol = 0;
   int          both_high = 0;
   int          acc_cnt = 0;
   logic        prev_rdwrb = 1'b0;
   logic [31:0] wq[$];

   always #5 clk = ~clk;

   icap_cfg_reg_reader_if bus();

   icap_cfg_reg_reader #(
      .READ_LAT       (READ_LAT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .bus         (bus),
      .icap_csib   (csib),
      .icap_rdwrb  (rdwrb),
      .icap_i      (icap_i),
      .icap_o      (icap_o),
      .icap_avail  (avail)
   );

   // ICAPE3 model: valid data only on the last read-phase cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              rdcnt <= 0;
      else if (!csib && rdwrb) rdcnt <= rdcnt + 1;
      else                     rdcnt <= 0;
   end
   assign icap_o = (!csib && rdwrb && rdcnt == READ_LAT - 1) ? rd_val : 32'h0;

   // Monitor: written words, turnaround rule, handshake exclusivity, accepts.
   always @(negedge clk) begin
      prev_rdwrb <= rdwrb;
      if (rst_n) begin
         if (!csib && !rdwrb) wq.push_back(icap_i);
         if (rdwrb !== prev_rdwrb && csib !== 1'b1) proto_viol <= proto_viol + 1;
         if (bus.rsp_valid && bus.req_ready) both_high <= both_high + 1;
         if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
      end
   end

   task automatic accept(input logic [4:0] a);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int limit, output int cyc);
      cyc = 0;
      while (bus.rsp_valid !== 1'b1 && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic take_rsp();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
      avail = 1'b1; rd_val = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.req_ready !== 1'b1)       begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0)       begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'h0)       begin errors++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
      checks++; if (bus.rsp_err !== 1'b0)         begin errors++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
      checks++; if (csib !== 1'b1)                begin errors++; $display("FAIL reset_csib got %b exp 1", csib); end
      checks++; if (rdwrb !== 1'b0)               begin errors++; $display("FAIL reset_rdwrb got %b exp 0", rdwrb); end
      checks++; if (icap_i !== 32'hFFFF_FFFF)     begin errors++; $display("FAIL reset_icap_i got %h exp FFFFFFFF", icap_i); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_bootsts();
      logic [31:0] exp_w[10] = '{32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000, 32'h1440_0380,
                                 32'h0400_0000, 32'h0400_0000,
                                 32'h0C00_0180, 32'h0000_00B0, 32'h0400_0000, 32'h0400_0000};
      int cyc;
      wq.delete();
      avail = 1'b1; rd_val = 32'h482C_6A1E;   // bitrev of 12345678
      accept(5'h16);
      wait_rsp(100, cyc);
      checks++; if (cyc !== 14 + READ_LAT) begin errors++; $display("FAIL bootsts_latency got %0d exp %0d", cyc, 14 + READ_LAT); end
      checks++; if (wq.size() !== 10) begin errors++; $display("FAIL bootsts_word_count got %0d exp 10", wq.size()); end
      for (int i = 0; i < 10; i++) begin
         if (i < wq.size()) begin
            checks++;
            if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL bootsts_word%0d got %h exp %h", i, wq[i], exp_w[i]); end
         end
      end
      checks++; if (bus.rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL bootsts_data got %h exp 12345678", bus.rsp_data); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL bootsts_err got %b exp 0", bus.rsp_err); end
      checks++; if (csib !== 1'b1) begin errors++; $display("FAIL bootsts_resp_csib got %b exp 1", csib); end
      take_rsp();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
         begin errors++; $display("FAIL bootsts_release got valid=%b ready=%b exp 0/1", bus.rsp_valid, bus.req_ready); end
   endtask

   task automatic test_idcode();
      int cyc;
      wq.delete();
      avail = 1'b1; rd_val = 32'h20AD_08C9;   // bitrev of 04B51093
      accept(5'h0C);
      wait_rsp(100, cyc);
      checks++; if (cyc !== 18) begin errors++; $display("FAIL idcode_latency got %0d exp 18", cyc); end
      checks++; if (wq.size() < 10 || wq[3] !== 32'h1480_0180)
         begin errors++; $display("FAIL idcode_read_hdr got %h exp 14800180", (wq.size() > 3) ? wq[3] : 32'hX); end
      checks++; if (wq.size() < 10 || wq[6] !== 32'h0C00_0180 || wq[7] !== 32'h0000_00B0)
         begin errors++; $display("FAIL idcode_desync got size %0d exp 10 with DESYNC words", wq.size()); end
      checks++; if (bus.rsp_data !== 32'h04B5_1093) begin errors++; $display("FAIL idcode_data got %h exp 04B51093", bus.rsp_data); end
      take_rsp();
   endtask

   task automatic test_avail_stall();
      int cyc;
      int bad = 0;
      wq.delete();
      avail = 1'b0; rd_val = 32'h482C_6A1E;
      accept(5'h16);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (csib !== 1'b1 || wq.size() != 0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall_idle_port got %0d bad cycles exp 0", bad); end
      avail = 1'b1;
      @(posedge clk); #1;
      checks++; if (csib !== 1'b0 || icap_i !== 32'hFFFF_FFFF)
         begin errors++; $display("FAIL stall_start got csib=%b i=%h exp 0/FFFFFFFF", csib, icap_i); end
      wait_rsp(100, cyc);
      checks++; if (cyc !== 17) begin errors++; $display("FAIL stall_latency got %0d exp 17", cyc); end
      checks++; if (bus.rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_data got %h exp 12345678", bus.rsp_data); end
      take_rsp();
   endtask

   task automatic test_back_to_back();
      int cyc;
      int bad = 0;
      logic [31:0] held;
      acc_cnt = 0;
      avail = 1'b1; rd_val = 32'h20AD_08C9;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 5'h0C;
      @(posedge clk); #1;
      wait_rsp(100, cyc);
      held = bus.rsp_data;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0) bad++;
      end
      checks++; if (held !== 32'h04B5_1093) begin errors++; $display("FAIL bp_data got %h exp 04B51093", held); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
      checks++; if (acc_cnt !== 1) begin errors++; $display("FAIL bp_single_accept got %0d exp 1", acc_cnt); end
      rd_val = 32'h482C_6A1E;
      bus.req_addr = 5'h16;
      @(negedge clk) bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;              // second request accepted here
      bus.req_valid = 1'b0;
      checks++; if (acc_cnt !== 2) begin errors++; $display("FAIL bp_second_accept got %0d exp 2", acc_cnt); end
      wait_rsp(100, cyc);
      checks++; if (bus.rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL bp_second_data got %h exp 12345678", bus.rsp_data); end
      take_rsp();
      checks++; if (both_high !== 0) begin errors++; $display("FAIL valid_ready_overlap got %0d exp 0", both_high); end
      checks++; if (proto_viol !== 0) begin errors++; $display("FAIL rdwrb_turnaround got %0d exp 0", proto_viol); end
   endtask

   task automatic test_timeout();
      int cyc;
      avail = 1'b0; rd_val = 32'h482C_6A1E;
      accept(5'h16);
`ifdef ICAP_RD_TIMEOUT_EN
      wait_rsp(400, cyc);
      checks++; if (cyc !== TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", cyc, TIMEOUT_CYCLES); end
      checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", bus.rsp_err); end
      checks++; if (bus.rsp_data !== 32'hDEAD_DEAD) begin errors++; $display("FAIL timeout_data got %h exp DEADDEAD", bus.rsp_data); end
      checks++; if (csib !== 1'b1) begin errors++; $display("FAIL timeout_csib got %b exp 1", csib); end
      take_rsp();
      avail = 1'b1;
`else
      wait_rsp(10000, cyc);
      checks++; if (bus.rsp_valid !== 1'b0 || csib !== 1'b1)
         begin errors++; $display("FAIL no_timeout got valid=%b csib=%b exp 0/1", bus.rsp_valid, csib); end
      avail = 1'b1;
      wait_rsp(100, cyc);
      checks++; if (bus.rsp_data !== 32'h1234_5678 || bus.rsp_err !== 1'b0)
         begin errors++; $display("FAIL no_timeout_data got %h err=%b exp 12345678/0", bus.rsp_data, bus.rsp_err); end
      take_rsp();
`endif
   endtask

   task automatic test_reset_mid_rd();
      int cyc;
      avail = 1'b1; rd_val = 32'h482C_6A1E;
      accept(5'h16);
      repeat (9) @(posedge clk);
      #1;
      checks++; if (csib !== 1'b0 || rdwrb !== 1'b1) begin errors++; $display("FAIL rst_in_rd got csib=%b rdwrb=%b exp 0/1", csib, rdwrb); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (csib !== 1'b1) begin errors++; $display("FAIL rst_async_csib got %b exp 1", csib); end
      checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
         begin errors++; $display("FAIL rst_async_hs got ready=%b valid=%b exp 1/0", bus.req_ready, bus.rsp_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus.req_ready); end
      accept(5'h16);
      wait_rsp(100, cyc);
      checks++; if (bus.rsp_data !== 32'h1234_5678 || cyc !== 18)
         begin errors++; $display("FAIL rst_followup got %h after %0d exp 12345678 after 18", bus.rsp_data, cyc); end
      take_rsp();
   endtask

   initial begin
      test_reset();
      test_bootsts();
      test_idcode();
      test_avail_stall();
      test_back_to_back();
      test_timeout();
      test_reset_mid_rd();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
